// File: rtl/hazard_ctrl_unit.sv
// Hazard control for the 5-stage ThinPad pipeline: load-use bubbles, memory-conflict stall FSM, mispredict flushes.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl_unit #(
  parameter int               REG_W            = 4,
  parameter logic [REG_W-1:0] NO_REG           = {REG_W{1'b1}},
  parameter int               MEM_STALL_CYCLES = 1,
  parameter bit               FLUSH_ID         = 1'b0,
  parameter int               PERF_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branch_err,
  input  logic [REG_W-1:0] rd_reg1,
  input  logic [REG_W-1:0] rd_reg2,
  input  logic             rd_use1,
  input  logic             rd_use2,
  input  logic [REG_W-1:0] ex_wreg,
  input  logic             ex_mem_read,
  input  logic             mem_conflict,
  output logic             pc_keep,
  output logic             if_keep,
  output logic             if_clear,
  output logic             id_keep,
  output logic             id_clear,
  output logic             exe_keep,
`ifdef HAZARD_PERF_CNT_EN
  input  logic              perf_clr,
  output logic [PERF_W-1:0] lu_cnt,
  output logic [PERF_W-1:0] ms_cnt,
  output logic [PERF_W-1:0] fl_cnt,
`endif
  output logic [1:0]       hz_state
);

  localparam int               CNT_W    = $clog2(MEM_STALL_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MSTALL  = 2'b01,
    RELEASE = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu_s;
  logic             lu_bubble_s;

  // Load-use: a pending load whose destination is really read by the ID instruction.
  assign lu_s = ex_mem_read && (ex_wreg != NO_REG) &&
                ((rd_use1 && (rd_reg1 == ex_wreg)) || (rd_use2 && (rd_reg2 == ex_wreg)));

  assign hz_state = state_q;

  // State and stall-countdown register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and keep/clear decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_keep     = 1'b0;
    if_keep     = 1'b0;
    if_clear    = 1'b0;
    id_keep     = 1'b0;
    id_clear    = 1'b0;
    exe_keep    = 1'b0;
    lu_bubble_s = 1'b0;
    if (rst) begin
      state_d = RUN;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_conflict) begin
            pc_keep  = 1'b1;
            if_keep  = 1'b1;
            id_keep  = 1'b1;
            exe_keep = 1'b1;
            if (MEM_STALL_CYCLES > 1) begin
              state_d = MSTALL;
              cnt_d   = CNT_INIT;
            end else begin
              state_d = RELEASE;
            end
          end else if (branch_err) begin
            // A load-use seen alongside a mispredict is on the wrong path.
            if_clear = 1'b1;
            id_clear = FLUSH_ID;
          end else if (lu_s) begin
            pc_keep     = 1'b1;
            if_keep     = 1'b1;
            id_clear    = 1'b1;
            lu_bubble_s = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        MSTALL: begin
          pc_keep  = 1'b1;
          if_keep  = 1'b1;
          id_keep  = 1'b1;
          exe_keep = 1'b1;
          cnt_d    = cnt_q - CNT_ONE;
          if (cnt_q <= CNT_ONE) begin
            state_d = RELEASE;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = MSTALL;
          end
        end
        RELEASE: begin
          // mem_conflict is deliberately ignored here so the held access can finish.
          state_d = RUN;
          if (branch_err) begin
            if_clear = 1'b1;
            id_clear = FLUSH_ID;
          end else if (lu_s) begin
            pc_keep     = 1'b1;
            if_keep     = 1'b1;
            id_clear    = 1'b1;
            lu_bubble_s = 1'b1;
          end else begin
            pc_keep = 1'b0;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] lu_cnt_q, ms_cnt_q, fl_cnt_q;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
    if (en && (v != {PERF_W{1'b1}})) begin
      return v + PERF_W'(1);
    end else begin
      return v;
    end
  endfunction

  // Saturating event counters; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      lu_cnt_q <= {PERF_W{1'b0}};
      ms_cnt_q <= {PERF_W{1'b0}};
      fl_cnt_q <= {PERF_W{1'b0}};
    end else begin
      lu_cnt_q <= sat_inc(lu_cnt_q, lu_bubble_s);
      ms_cnt_q <= sat_inc(ms_cnt_q, exe_keep);
      fl_cnt_q <= sat_inc(fl_cnt_q, if_clear);
    end
  end

  assign lu_cnt = lu_cnt_q;
  assign ms_cnt = ms_cnt_q;
  assign fl_cnt = fl_cnt_q;
`else
  logic unused_lu_s;
  assign unused_lu_s = lu_bubble_s;
`endif

endmodule
